irq_scheduler: RTL and testbench
================================

Name: irq_scheduler

Overview:
- Arbitrates several peripheral interrupt sources (timer, UART rx/tx, ...) into the single IRQ input of the instruction decoder in the 5-stage pipelined MIPS CPU.
- Holds per-source pending bits and a software-written enable mask.
- Injects a one-cycle IRQ only into a clean ID-stage slot (valid, not stalled, not flushed, user mode), then blocks further injection until the handler returns from kernel mode.

Parameters:
NUM_SRC, 4, number of interrupt sources; index 0 is highest priority
CAUSE_W, 2, width of cause index; must equal ceil(log2(NUM_SRC)), minimum 1

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
src_req  in  NUM_SRC  per-source interrupt request from peripherals
mask_wr  in  1  one-cycle write strobe for enable mask (memory-mapped store)
mask_wdata  in  NUM_SRC  new enable mask; bit i set enables source i
clr_wr  in  1  one-cycle pending-clear strobe (memory-mapped store)
clr_id  in  CAUSE_W  source index cleared by clr_wr
id_valid  in  1  ID stage holds a real instruction, not a bubble
id_stall  in  1  ID held by load-use stall this cycle
id_flush  in  1  ID instruction being flushed by taken branch/jump
kernel_mode  in  1  PC[31] of the ID-stage instruction
IRQ  out  1  interrupt request to decoder; PCSrc=100 taken that cycle
irq_cause  out  CAUSE_W  index of the last injected source (registered)
irq_pending  out  NUM_SRC  pending register, readable by software
irq_mask  out  NUM_SRC  enable mask register, readable by software

Behaviour:
- Reset: state IDLE, pending=0, mask=0, irq_cause=0, IRQ=0. Any operation in flight is dropped.
- Pending update, every cycle:
  - pending[i] <= (pending[i] & ~(clr_wr & clr_id==i)) | set[i].
  - set[i] comes from the source sampling mode (see Optional Feature).
  - Set and clear of the same bit in the same cycle: set wins.
  - clr_id >= NUM_SRC is ignored.
- Mask: mask <= mask_wdata on mask_wr. The new value is visible to arbitration the next cycle.
- eligible = pending & mask. winner = lowest set index of eligible.
- States:
  - IDLE -> ARM when eligible != 0 and !kernel_mode.
  - ARM:
    - IRQ = id_valid & !id_stall & !id_flush & !kernel_mode & (eligible != 0). This is combinational within the cycle.
    - On an IRQ cycle: irq_cause <= winner, next state SERVICE.
    - If eligible becomes 0 (mask write or clear) with no IRQ: back to IDLE, no IRQ.
  - SERVICE:
    - IRQ=0.
    - -> IDLE on the first cycle with id_valid & !kernel_mode, i.e. the handler has returned via jr $k0.
    - A further eligible source re-arms from IDLE the following cycle.
- IRQ is never asserted in IDLE or SERVICE. It is never high for two consecutive cycles.
- The pending bit is not auto-cleared on injection. The handler must clear it via clr_wr.
- Latency: source pending in user mode with a clean ID slot gives IRQ two cycles after pending sets (IDLE->ARM, then ARM asserts).

Optional Feature:
- Macro IRQ_SRC_EDGE_EN.
- Defined:
  - src_req is registered once (src_q, reset 0).
  - set[i] = src_req[i] & ~src_q[i], so a rising edge sets pending.
  - A held-high source fires only once until it is cleared and re-raised.
- Undefined:
  - Level mode: set[i] = src_req[i].
  - A clr_wr while the source is still high has no net effect (set wins).
  - No src_q register exists.

Decomposition:
- Shared package (cpu_pkg): state encoding constants IRQ_IDLE=2'd0, IRQ_ARM=2'd1, IRQ_SVC=2'd2; default NUM_SRC/CAUSE_W; PCSrc code for IRQ (3'b100) for cross-checking with the decoder.
- One natural sub-module: irq_prio_enc (combinational lowest-index priority encoder, NUM_SRC -> CAUSE_W plus any-valid flag).

Test Plan:
- Reset then src_req=4'b0100, mask=4'b1111, clean ID slot, user mode -> IRQ pulses exactly once, irq_cause=2, state SERVICE; pending[2] stays 1 until clr_wr clr_id=2.
- src_req=4'b1010 simultaneously, mask=4'b1111 -> IRQ with irq_cause=1. After kernel_mode falls and clr_id=1, a second IRQ with irq_cause=3.
- ARM with id_stall=1 for 3 cycles, then id_flush=1 for 1 cycle, then clean -> IRQ only in the 5th ARM cycle.
- pending[0]=1, mask=0 -> no IRQ for 20 cycles. mask_wr 4'b0001 -> IRQ within 2 cycles. In ARM, a mask write to 0 -> back to IDLE with no IRQ.
- kernel_mode=1 with pending set -> no IRQ. Source pending during SERVICE -> no IRQ until kernel_mode=0 with id_valid, then re-arm.
- Reset asserted in ARM and in SERVICE -> next cycle IDLE, pending=0, mask=0, IRQ=0. With IRQ_SRC_EDGE_EN defined, src_req held high for 10 cycles -> pending sets once.

Source files
------------

// File: rtl/irq_scheduler_pkg.sv
// Shared constants for the interrupt scheduler: FSM state encoding, default sizing,
// and the decoder PCSrc code that an injected IRQ selects.
package irq_scheduler_pkg;

  localparam int DEF_NUM_SRC = 4;
  localparam int DEF_CAUSE_W = 2;

  // Decoder PCSrc selection taken when IRQ is high; kept here so both sides agree.
  localparam logic [2:0] PCSRC_IRQ = 3'b100;

  typedef enum logic [1:0] {
    IRQ_IDLE = 2'd0,
    IRQ_ARM  = 2'd1,
    IRQ_SVC  = 2'd2
  } irq_state_e;

endpackage

// File: rtl/irq_scheduler_if.sv
// Peripheral/CPU-facing bundle of the interrupt scheduler.
// The CPU/peripheral side drives through master; the scheduler consumes through slave.
interface irq_scheduler_if #(
  parameter int NUM_SRC = 4,
  parameter int CAUSE_W = 2
);

  logic [NUM_SRC-1:0] src_req;
  logic               mask_wr;
  logic [NUM_SRC-1:0] mask_wdata;
  logic               clr_wr;
  logic [CAUSE_W-1:0] clr_id;
  logic               id_valid;
  logic               id_stall;
  logic               id_flush;
  logic               kernel_mode;
  logic               IRQ;
  logic [CAUSE_W-1:0] irq_cause;
  logic [NUM_SRC-1:0] irq_pending;
  logic [NUM_SRC-1:0] irq_mask;

  modport master (
    output src_req, mask_wr, mask_wdata, clr_wr, clr_id,
    output id_valid, id_stall, id_flush, kernel_mode,
    input  IRQ, irq_cause, irq_pending, irq_mask
  );

  modport slave (
    input  src_req, mask_wr, mask_wdata, clr_wr, clr_id,
    input  id_valid, id_stall, id_flush, kernel_mode,
    output IRQ, irq_cause, irq_pending, irq_mask
  );

endinterface

// File: rtl/irq_scheduler_prio_enc.sv
// Lowest-index-wins priority encoder; purely combinational, zero latency.
// No flow control: o_any qualifies o_idx, which is 0 when nothing is requested.
module irq_scheduler_prio_enc #(
  parameter int NUM_SRC = 4,
  parameter int CAUSE_W = 2
) (
  input  logic [NUM_SRC-1:0] i_req,
  output logic [CAUSE_W-1:0] o_idx,
  output logic               o_any
);

  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    // Scan downward so the lowest set index is the last one written.
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_idx = CAUSE_W'(i);
        o_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_scheduler.sv
// Interrupt scheduler: pending/mask registers, arbitration, one-cycle IRQ into a clean ID slot.
// IRQ two cycles after a source pends; IRQ_SRC_EDGE_EN selects rising-edge instead of level sampling.
module irq_scheduler
  import irq_scheduler_pkg::*;
#(
  parameter int NUM_SRC = DEF_NUM_SRC,
  parameter int CAUSE_W = DEF_CAUSE_W
) (
  input  logic           clk,
  input  logic           reset,
  irq_scheduler_if.slave bus
);

  irq_state_e         r_state;
  irq_state_e         w_state_nxt;
  logic [NUM_SRC-1:0] r_pending;
  logic [NUM_SRC-1:0] r_mask;
  logic [CAUSE_W-1:0] r_cause;
  logic [NUM_SRC-1:0] w_set;
  logic [NUM_SRC-1:0] w_clr;
  logic [NUM_SRC-1:0] w_eligible;
  logic [CAUSE_W-1:0] w_winner;
  logic               w_any;
  logic               w_irq;

`ifdef IRQ_SRC_EDGE_EN
  logic [NUM_SRC-1:0] r_src_q;

  always_ff @(posedge clk) begin
    if (reset) r_src_q <= '0;
    else       r_src_q <= bus.src_req;
  end

  assign w_set = bus.src_req & ~r_src_q;
`else
  assign w_set = bus.src_req;
`endif

  // Out-of-range clr_id never matches an index below NUM_SRC, so it is ignored.
  always_comb begin
    w_clr = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_clr[i] = bus.clr_wr && (bus.clr_id == CAUSE_W'(i));
    end
  end

  assign w_eligible = r_pending & r_mask;

  irq_scheduler_prio_enc #(
    .NUM_SRC (NUM_SRC),
    .CAUSE_W (CAUSE_W)
  ) u_prio_enc (
    .i_req (w_eligible),
    .o_idx (w_winner),
    .o_any (w_any)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_irq       = 1'b0;
    case (r_state)
      IRQ_IDLE: begin
        if (w_any && !bus.kernel_mode) w_state_nxt = IRQ_ARM;
      end
      IRQ_ARM: begin
        w_irq = bus.id_valid && !bus.id_stall && !bus.id_flush && !bus.kernel_mode && w_any;
        if (w_irq)       w_state_nxt = IRQ_SVC;
        else if (!w_any) w_state_nxt = IRQ_IDLE;
      end
      IRQ_SVC: begin
        // A valid user-mode instruction in ID means the handler has returned.
        if (bus.id_valid && !bus.kernel_mode) w_state_nxt = IRQ_IDLE;
      end
      default: w_state_nxt = IRQ_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IRQ_IDLE;
      r_pending <= '0;
      r_mask    <= '0;
      r_cause   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= (r_pending & ~w_clr) | w_set;
      if (bus.mask_wr) r_mask  <= bus.mask_wdata;
      if (w_irq)       r_cause <= w_winner;
    end
  end

  assign bus.IRQ         = w_irq;
  assign bus.irq_cause   = r_cause;
  assign bus.irq_pending = r_pending;
  assign bus.irq_mask    = r_mask;

endmodule

// File: tb/tb_irq_scheduler.sv
// Bench for irq_scheduler: directed vector table, hand-written corner sequences,
// and randomized traffic against a cycle-level reference model.
module tb_irq_scheduler;

  localparam int N  = 4;
  localparam int CW = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  irq_scheduler_if #(.NUM_SRC(N), .CAUSE_W(CW)) bus ();

  irq_scheduler #(.NUM_SRC(N), .CAUSE_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: pending/mask sets, cause, and an injection phase
  // (0 waiting, 1 armed, 2 handler running).
  bit [N-1:0] m_pend, m_mask, m_srcq;
  int         m_cause, m_phase;
  bit         m_prev_irq;

  // Sampled DUT outputs of the most recent cycle.
  logic          s_irq;
  logic [CW-1:0] s_cause;
  logic [N-1:0]  s_pend, s_mask;

  typedef struct {
    logic [N-1:0]  src;
    logic          mw;
    logic [N-1:0]  md;
    logic          cw;
    logic [CW-1:0] cid;
    logic          v, st, fl, km;
    logic          e_irq;
    logic [CW-1:0] e_cause;
    logic [N-1:0]  e_pend;
  } vec_t;

  vec_t tbl[7];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lowest(input bit [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic bit m_irq();
    return (m_phase == 1) && bus.id_valid && !bus.id_stall && !bus.id_flush &&
           !bus.kernel_mode && ((m_pend & m_mask) != '0);
  endfunction

  task automatic model_step();
    bit [N-1:0] elig, setv, newp;
    bit         fire;
    if (reset) begin
      m_pend = '0; m_mask = '0; m_srcq = '0; m_cause = 0; m_phase = 0;
      return;
    end
    elig = m_pend & m_mask;
    fire = m_irq();
`ifdef IRQ_SRC_EDGE_EN
    setv = bus.src_req & ~m_srcq;
`else
    setv = bus.src_req;
`endif
    for (int i = 0; i < N; i++)
      newp[i] = (m_pend[i] && !(bus.clr_wr && (bus.clr_id == i))) || setv[i];
    case (m_phase)
      0: if (elig != '0 && !bus.kernel_mode) m_phase = 1;
      1: begin
        if (fire) begin
          m_cause = lowest(elig);
          m_phase = 2;
        end else if (elig == '0) begin
          m_phase = 0;
        end
      end
      default: if (bus.id_valid && !bus.kernel_mode) m_phase = 0;
    endcase
    if (bus.mask_wr) m_mask = bus.mask_wdata;
    m_srcq = bus.src_req;
    m_pend = newp;
  endtask

  // One clock: drive inputs, compare against the model mid-cycle, advance the model.
  task automatic cyc(input logic [N-1:0] src, input logic mw, input logic [N-1:0] md,
                     input logic cw, input logic [CW-1:0] cid,
                     input logic v, input logic st, input logic fl, input logic km);
    bus.src_req = src; bus.mask_wr = mw; bus.mask_wdata = md;
    bus.clr_wr = cw; bus.clr_id = cid;
    bus.id_valid = v; bus.id_stall = st; bus.id_flush = fl; bus.kernel_mode = km;
    #2;
    s_irq = bus.IRQ; s_cause = bus.irq_cause; s_pend = bus.irq_pending; s_mask = bus.irq_mask;
    cmp("irq", {31'd0, s_irq}, {31'd0, m_irq()});
    cmp("cause", {30'd0, s_cause}, m_cause);
    cmp("pending", {28'd0, s_pend}, {28'd0, m_pend});
    cmp("mask", {28'd0, s_mask}, {28'd0, m_mask});
    if (m_prev_irq) cmp("irq_back_to_back", {31'd0, s_irq}, 32'd0);
    m_prev_irq = s_irq;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc('0, 0, '0, 0, '0, 0, 0, 0, 0);
    reset = 1'b0;
  endtask

  task automatic set_mask(input logic [N-1:0] m);
    cyc('0, 1, m, 0, '0, 0, 0, 0, 0);
  endtask

  task automatic run_clean(input int n, input logic v, input logic km, output int cnt);
    cnt = 0;
    repeat (n) begin
      cyc('0, 0, '0, 0, '0, v, 0, 0, km);
      if (s_irq) cnt++;
    end
  endtask

  task automatic wait_irq(input int bound, output bit got);
    got = 1'b0;
    for (int k = 0; k < bound && !got; k++) begin
      cyc('0, 0, '0, 0, '0, 1, 0, 0, 0);
      got = s_irq;
    end
  endtask

  initial begin
    int cnt;
    bit got;
    logic [4:0] pat;

    // Reset state.
    reset = 1'b1;
    bus.src_req = '0; bus.mask_wr = 0; bus.mask_wdata = '0; bus.clr_wr = 0; bus.clr_id = '0;
    bus.id_valid = 0; bus.id_stall = 0; bus.id_flush = 0; bus.kernel_mode = 0;
    m_pend = '0; m_mask = '0; m_srcq = '0; m_cause = 0; m_phase = 0; m_prev_irq = 0;
    repeat (2) @(posedge clk);
    #3;
    cmp("rst_irq", {31'd0, bus.IRQ}, 32'd0);
    cmp("rst_cause", {30'd0, bus.irq_cause}, 32'd0);
    cmp("rst_pending", {28'd0, bus.irq_pending}, 32'd0);
    cmp("rst_mask", {28'd0, bus.irq_mask}, 32'd0);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Single source 2: one pulse, cause 2, pending held until cleared.
    //           src      mw  md       cw  cid    v  st fl km  irq cause  pend
    tbl[0] = '{4'b0100, 1, 4'b1111, 0, 2'd0, 1, 0, 0, 0, 0, 2'd0, 4'b0000};
    tbl[1] = '{4'b0000, 0, 4'b0000, 0, 2'd0, 1, 0, 0, 0, 0, 2'd0, 4'b0100};
    tbl[2] = '{4'b0000, 0, 4'b0000, 0, 2'd0, 1, 0, 0, 0, 1, 2'd0, 4'b0100};
    tbl[3] = '{4'b0000, 0, 4'b0000, 0, 2'd0, 1, 0, 0, 1, 0, 2'd2, 4'b0100};
    tbl[4] = '{4'b0000, 0, 4'b0000, 1, 2'd2, 1, 0, 0, 1, 0, 2'd2, 4'b0100};
    tbl[5] = '{4'b0000, 0, 4'b0000, 0, 2'd0, 1, 0, 0, 0, 0, 2'd2, 4'b0000};
    tbl[6] = '{4'b0000, 0, 4'b0000, 0, 2'd0, 1, 0, 0, 0, 0, 2'd2, 4'b0000};
    for (int i = 0; i < 7; i++) begin
      cyc(tbl[i].src, tbl[i].mw, tbl[i].md, tbl[i].cw, tbl[i].cid,
          tbl[i].v, tbl[i].st, tbl[i].fl, tbl[i].km);
      cmp($sformatf("tbl%0d_irq", i), {31'd0, s_irq}, {31'd0, tbl[i].e_irq});
      cmp($sformatf("tbl%0d_cause", i), {30'd0, s_cause}, {30'd0, tbl[i].e_cause});
      cmp($sformatf("tbl%0d_pend", i), {28'd0, s_pend}, {28'd0, tbl[i].e_pend});
    end

    // Two simultaneous sources: 1 wins, then 3 after return and clear.
    do_reset();
    set_mask(4'b1111);
    cyc(4'b1010, 0, '0, 0, '0, 1, 0, 0, 0);
    wait_irq(5, got);
    cmp("s2_first_irq", {31'd0, got}, 32'd1);
    cyc('0, 0, '0, 1, 2'd1, 1, 0, 0, 1);
    cmp("s2_first_cause", {30'd0, s_cause}, 32'd1);
    cyc('0, 0, '0, 0, '0, 1, 0, 0, 0);
    wait_irq(5, got);
    cmp("s2_second_irq", {31'd0, got}, 32'd1);
    cyc('0, 0, '0, 1, 2'd3, 1, 0, 0, 1);
    cmp("s2_second_cause", {30'd0, s_cause}, 32'd3);

    // Armed slot blocked by stall x3 then flush x1; fires on the 5th armed cycle.
    do_reset();
    set_mask(4'b1111);
    cyc(4'b0001, 0, '0, 0, '0, 1, 0, 0, 0);
    cyc('0, 0, '0, 0, '0, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc('0, 0, '0, 0, '0, 1, 1, 0, 0);
      pat[i] = s_irq;
    end
    cyc('0, 0, '0, 0, '0, 1, 0, 1, 0);
    pat[3] = s_irq;
    cyc('0, 0, '0, 0, '0, 1, 0, 0, 0);
    pat[4] = s_irq;
    cmp("s3_arm_pattern", {27'd0, pat}, 32'b10000);

    // Masked pending source stays silent; enabling it fires two cycles later;
    // masking it again while armed returns to idle without a pulse.
    do_reset();
    cyc(4'b0001, 0, '0, 0, '0, 1, 0, 0, 0);
    run_clean(20, 1, 0, cnt);
    cmp("s4_masked_quiet", cnt, 32'd0);
    cyc('0, 1, 4'b0001, 0, '0, 1, 0, 0, 0);
    run_clean(2, 1, 0, cnt);
    cmp("s4_unmask_irq", cnt, 32'd1);
    cyc('0, 0, '0, 0, '0, 1, 0, 0, 1);
    cyc('0, 0, '0, 0, '0, 1, 0, 0, 0);
    cyc('0, 0, '0, 0, '0, 0, 0, 0, 0);
    cyc('0, 1, 4'b0000, 0, '0, 0, 0, 0, 0);
    run_clean(5, 1, 0, cnt);
    cmp("s4_arm_masked_quiet", cnt, 32'd0);

    // Kernel mode blocks arming; a source raised during service waits for return.
    do_reset();
    set_mask(4'b1111);
    cyc(4'b0100, 0, '0, 0, '0, 1, 0, 0, 1);
    run_clean(10, 1, 1, cnt);
    cmp("s5_kernel_quiet", cnt, 32'd0);
    wait_irq(4, got);
    cmp("s5_user_irq", {31'd0, got}, 32'd1);
    cyc(4'b0010, 0, '0, 0, '0, 1, 0, 0, 1);
    run_clean(5, 1, 1, cnt);
    cmp("s5_service_quiet", cnt, 32'd0);
    wait_irq(4, got);
    cmp("s5_rearm_irq", {31'd0, got}, 32'd1);
    cyc('0, 0, '0, 0, '0, 1, 0, 0, 1);
    cmp("s5_rearm_cause", {30'd0, s_cause}, 32'd1);

    // Reset while armed.
    do_reset();
    set_mask(4'b1111);
    cyc(4'b0001, 0, '0, 0, '0, 0, 0, 0, 0);
    cyc('0, 0, '0, 0, '0, 0, 0, 0, 0);
    reset = 1'b1;
    cyc('0, 0, '0, 0, '0, 0, 0, 0, 0);
    reset = 1'b0;
    cyc('0, 0, '0, 0, '0, 1, 0, 0, 0);
    cmp("s6_arm_rst_irq", {31'd0, s_irq}, 32'd0);
    cmp("s6_arm_rst_pend", {28'd0, s_pend}, 32'd0);
    cmp("s6_arm_rst_mask", {28'd0, s_mask}, 32'd0);

    // Reset while in service.
    do_reset();
    set_mask(4'b1111);
    cyc(4'b0100, 0, '0, 0, '0, 1, 0, 0, 0);
    cyc('0, 0, '0, 0, '0, 1, 0, 0, 0);
    cyc('0, 0, '0, 0, '0, 1, 0, 0, 0);
    cyc('0, 0, '0, 0, '0, 1, 0, 0, 1);
    cmp("s6_svc_cause_pre", {30'd0, s_cause}, 32'd2);
    reset = 1'b1;
    cyc('0, 0, '0, 0, '0, 1, 0, 0, 1);
    reset = 1'b0;
    cyc('0, 0, '0, 0, '0, 1, 0, 0, 0);
    cmp("s6_svc_rst_irq", {31'd0, s_irq}, 32'd0);
    cmp("s6_svc_rst_cause", {30'd0, s_cause}, 32'd0);
    cmp("s6_svc_rst_pend", {28'd0, s_pend}, 32'd0);
    cmp("s6_svc_rst_mask", {28'd0, s_mask}, 32'd0);

`ifdef IRQ_SRC_EDGE_EN
    // Held-high source pends once; after a clear it does not re-pend.
    do_reset();
    for (int i = 0; i < 10; i++)
      cyc(4'b1000, 0, '0, (i == 3), 2'd3, 1, 0, 0, 1);
    cyc('0, 0, '0, 0, '0, 1, 0, 0, 1);
    cmp("edge_held_once", {28'd0, s_pend}, 32'd0);
`endif

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) reset = 1'b1;
      cyc(N'($urandom_range(0, 7) == 0 ? $urandom : 0),
          ($urandom_range(0, 15) == 0), N'($urandom),
          ($urandom_range(0, 3) == 0), CW'($urandom_range(0, N - 1)),
          ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0));
      reset = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
